// File: rtl/ibus_line_buffer.sv
// Single-line fetch buffer: turns ibus misses into CBus INCR line fills.
// Optional early restart during a fill: IBUF_EARLY_RESTART_EN.
package ibus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_t;

  typedef enum logic [2:0] {
    SIZE_1 = 3'd0,
    SIZE_2 = 3'd1,
    SIZE_4 = 3'd2,
    SIZE_8 = 3'd3
  } cbus_size_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module ibus_line_buffer
  import ibus_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  input  logic       flush,
  output logic       busy
);

  localparam int OFS_BITS = $clog2(8 * LINE_WORDS);
  localparam int IDX_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = 64 - OFS_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t              state;
  logic                line_valid;
  logic                discard;
  logic [TAG_BITS-1:0] line_tag;
  logic [IDX_BITS-1:0] cnt;
  logic [63:0]         data_q [LINE_WORDS];

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic                tag_eq;
  logic                hit;
  logic                miss;
  logic                cnt_full;
  logic                unused_addr_bits;

  assign req_tag  = ireq.addr[63:OFS_BITS];
  assign req_idx  = ireq.addr[OFS_BITS-1:3];
  assign tag_eq   = (req_tag == line_tag);
  assign cnt_full = (cnt == IDX_BITS'(LINE_WORDS - 1));

  assign unused_addr_bits = ^ireq.addr[1:0];

  assign hit = ireq.valid & line_valid & tag_eq
             & (state == IDLE) & ~flush;

  assign miss = ireq.valid & ~flush & (state == IDLE)
              & ~(line_valid & tag_eq);

`ifdef IBUF_EARLY_RESTART_EN
  logic er_ok;
  logic er_live;
  logic er_held;

  // A same-cycle flush also blocks the response: the line is going stale.
  assign er_ok = (state == FILL) & ireq.valid & tag_eq
               & ~discard & ~flush;

  assign er_live = er_ok & oresp.ready & (req_idx == cnt);
  assign er_held = er_ok & (req_idx < cnt);
`endif

  logic [63:0] src;
  logic        serve;

  always_comb begin
    iresp = '0;
    src   = data_q[req_idx];
    serve = hit;
`ifdef IBUF_EARLY_RESTART_EN
    if (er_live) begin
      serve = 1'b1;
      src   = oresp.data;
    end else if (er_held) begin
      serve = 1'b1;
    end
`endif
    if (serve) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = ireq.addr[2] ? src[63:32] : src[31:0];
    end
  end

  // oreq is a pure function of registered state, so it is stable per burst.
  always_comb begin
    oreq = '0;
    if (state == FILL) begin
      oreq.valid    = 1'b1;
      oreq.is_write = 1'b0;
      oreq.size     = SIZE_8;
      oreq.addr     = {line_tag, {OFS_BITS{1'b0}}};
      oreq.strobe   = '0;
      oreq.len      = 4'(LINE_WORDS - 1);
      oreq.burst    = BURST_INCR;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      line_valid <= 1'b0;
      discard    <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            line_valid <= 1'b0;
          end else if (miss) begin
            line_tag   <= req_tag;
            cnt        <= '0;
            line_valid <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (flush) discard <= 1'b1;
          if (oresp.ready) begin
            cnt <= cnt + IDX_BITS'(1);
            if (oresp.last) begin
              discard <= 1'b0;
              if (cnt_full) begin
                line_valid <= ~discard & ~flush;
                state      <= IDLE;
              end else begin
                line_valid <= 1'b0;
                state      <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          line_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && oresp.ready) begin
      data_q[cnt] <= oresp.data;
    end
  end

endmodule
